// File: rtl/rom_bank_sel.sv
// Serial ROM-bank controller: captures 10-bit instructions shifted on `is` during `sync`,
// decodes immediate/delayed ROM selects, and polices instruction framing and sync loss.
module rom_bank_sel #(
  parameter int NBANK      = 8,
  parameter int BW         = 3,
  parameter int RESET_BANK = 0,
  parameter int WD_LIMIT   = 63
) (
  input  logic             cph2,
  input  logic             pon,
  input  logic             sync,
  input  logic             is,
  output logic [NBANK-1:0] rom_en,
  output logic [BW-1:0]    bank,
  output logic             pend_valid,
  output logic             sel_strobe,
  output logic             instr_err,
  output logic             sync_lost
);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

  localparam int             WDW      = $clog2(WD_LIMIT + 1);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(WD_LIMIT);
  localparam logic [BW-1:0]  RST_BANK = BW'(RESET_BANK);
  localparam logic [NBANK-1:0] ONE    = NBANK'(1);
  localparam logic [6:0]     OP_IMM   = 7'b001_0000;
  localparam logic [6:0]     OP_DEL   = 7'b011_0100;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [9:0]       ibuf_q, ibuf_d;
  logic [BW-1:0]    bank_q, bank_d;
  logic [BW-1:0]    pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [NBANK-1:0] rom_en_q, rom_en_d;
  logic             sel_strobe_q, sel_strobe_d;
  logic             instr_err_q, instr_err_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             sync_lost_q, sync_lost_d;
  logic             sync_prev_q, sync_prev_d;
  logic             sync_rise;
  logic [2:0]       tgt;
  logic             tgt_ok;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ibuf_d       = ibuf_q;
    bank_d       = bank_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    sel_strobe_d = 1'b0;
    instr_err_d  = 1'b0;
    sync_lost_d  = sync_lost_q;
    sync_prev_d  = sync;
    sync_rise    = sync & ~sync_prev_q;
    tgt          = ibuf_q[9:7];
    tgt_ok       = (32'(tgt) < 32'(NBANK));

    if (sync) ibuf_d = {is, ibuf_q[9:1]};

    if (sync_rise)            wd_d = '0;
    else if (wd_q == WD_MAX)  wd_d = WD_MAX;
    else                      wd_d = wd_q + WDW'(1);
    if (wd_d == WD_MAX) sync_lost_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = SHIFT;
          cnt_d   = 4'd1;
        end
      end
      SHIFT: begin
        if (sync) begin
          cnt_d = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
        end else if (cnt_q == 4'd10) begin
          state_d     = DECODE;
          sync_lost_d = 1'b0;
        end else begin
          state_d     = IDLE;
          instr_err_d = 1'b1;
        end
      end
      DECODE: begin
        if (sync) begin
          // sync came back before the decode slot finished: treat as a new, misframed word
          state_d     = SHIFT;
          cnt_d       = 4'd1;
          instr_err_d = 1'b1;
        end else begin
          state_d = IDLE;
          if (ibuf_q[6:0] == OP_IMM) begin
            if (!tgt_ok) instr_err_d = 1'b1;
            else if (!sync_lost_q) begin
              bank_d       = BW'(tgt);
              pend_valid_d = 1'b0;
            end
          end else if (ibuf_q[6:0] == OP_DEL) begin
            if (!tgt_ok) instr_err_d = 1'b1;
            else if (!sync_lost_q) begin
              pend_d       = BW'(tgt);
              pend_valid_d = 1'b1;
            end
          end else if (ibuf_q[0] && pend_valid_q && !sync_lost_q) begin
            bank_d       = pend_q;
            pend_valid_d = 1'b0;
          end
          sel_strobe_d = (bank_d != bank_q);
        end
      end
      default: state_d = IDLE;
    endcase

    rom_en_d = ONE << bank_d;
  end

  always_ff @(posedge cph2 or posedge pon) begin
    if (pon) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ibuf_q       <= '0;
      bank_q       <= RST_BANK;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      rom_en_q     <= ONE << RST_BANK;
      sel_strobe_q <= 1'b0;
      instr_err_q  <= 1'b0;
      wd_q         <= '0;
      sync_lost_q  <= 1'b0;
      sync_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ibuf_q       <= ibuf_d;
      bank_q       <= bank_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      rom_en_q     <= rom_en_d;
      sel_strobe_q <= sel_strobe_d;
      instr_err_q  <= instr_err_d;
      wd_q         <= wd_d;
      sync_lost_q  <= sync_lost_d;
      sync_prev_q  <= sync_prev_d;
    end
  end

  assign rom_en     = rom_en_q;
  assign bank       = bank_q;
  assign pend_valid = pend_valid_q;
  assign sel_strobe = sel_strobe_q;
  assign instr_err  = instr_err_q;
  assign sync_lost  = sync_lost_q;

endmodule

// File: doc/rom_bank_sel.md
Name: rom_bank_sel

Overview:
- Serial ROM-bank controller that sits beside the control/timing circuit on the instruction bus.
- Captures each 10-bit instruction word shifted on `is` while `sync` is high.
- Decodes the immediate and delayed ROM-select instructions and drives a one-hot enable that selects which ROM bank answers the next address word.
- Also polices instruction framing: sync pulse length, and sync loss via a watchdog.

Parameters:
- NBANK, 8: number of ROM banks; width of rom_en.
- BW, 3: bank index width; must satisfy 2^BW >= NBANK.
- RESET_BANK, 0: bank active after reset.
- WD_LIMIT, 63: cycles between sync rising edges before sync_lost is asserted.

Ports:
- cph2  in  1  system clock; all state updates on its posedge.
- pon  in  1  asynchronous, active-high reset.
- sync  in  1  instruction-valid window; exactly 10 cycles high per 56-cycle word.
- is  in  1  serial instruction, LSB first, valid while sync is high.
- rom_en  out  NBANK  one-hot bank enable.
- bank  out  BW  index of the active bank.
- pend_valid  out  1  a delayed select is armed.
- sel_strobe  out  1  one-cycle pulse when bank changes.
- instr_err  out  1  one-cycle pulse: framing error, or select target >= NBANK.
- sync_lost  out  1  level; watchdog expired.

Behaviour:
- Reset (pon=1, asynchronous) sets:
  - bank=RESET_BANK, rom_en=1<<RESET_BANK;
  - pend_valid=0, pend=0, sel_strobe=0, instr_err=0, sync_lost=0;
  - FSM=IDLE, bit counter=0, shift register=0, watchdog=0.
- Shift register ibuf[9:0]: each cycle with sync=1, ibuf <= {is, ibuf[9:1]}. After 10 bits, ibuf[0] holds the first bit received.
- FSM states IDLE, SHIFT, DECODE:
  - IDLE: sync=1 → SHIFT, bit counter=1, first bit shifted in.
  - SHIFT: while sync=1, shift and increment the counter, saturating at 15.
  - SHIFT: sync=0 → DECODE if counter==10; otherwise pulse instr_err, do not decode, → IDLE.
  - DECODE (exactly one cycle, corresponds to T55): apply the decode rules below, → IDLE. sync=1 during DECODE is a framing error: pulse instr_err, → SHIFT with counter=1.
- Decode rules, in priority order, evaluated on ibuf. Target t=ibuf[9:7].
  - Immediate select, ibuf[6:0]==7'b001_0000:
    - t<NBANK: bank<=t, pend_valid<=0.
    - t>=NBANK: instr_err pulse, no state change.
  - Delayed select, ibuf[6:0]==7'b011_0100:
    - t<NBANK: pend<=t, pend_valid<=1. A later delayed select overwrites pend.
    - t>=NBANK: instr_err pulse, pend unchanged.
  - Jump, ibuf[1:0]==2'b01 (JSB) or 2'b11 (GTO), with pend_valid=1: bank<=pend, pend_valid<=0. Applied regardless of carry.
  - Anything else: no effect.
- Timing of updates:
  - bank, rom_en and pend_valid update on the DECODE cycle edge, so the new bank is visible from T0 of the next word.
  - sel_strobe is high for that one cycle only if the new bank differs from the old; reselecting the current bank gives no strobe.
- rom_en is always exactly one-hot and equals 1<<bank, including the first cycle after reset.
- Watchdog:
  - Counts cycles, clears on each sync rising edge, and saturates at WD_LIMIT.
  - Reaching WD_LIMIT sets sync_lost=1.
  - sync_lost clears on the first cycle of the next 10-cycle-valid instruction that reaches DECODE.
  - While sync_lost=1, bank and pend hold; instructions still decode.
- Reset asserted mid-SHIFT: partial instruction discarded, nothing decoded, outputs at reset values immediately.

Test Plan:
1. Reset, then 4 words with no selects → rom_en=8'h01, bank=0, sel_strobe never high, sync_lost=0.
2. Immediate select to bank 5 (ibuf=10'b101_001_0000) → at the DECODE edge bank=5, rom_en=8'h20, one sel_strobe pulse; repeating the word gives no strobe.
3. Delayed select to 3 (10'b011_011_0100), then a non-jump word, then JSB (ibuf[1:0]=01):
   - pend_valid=1 after word 1 and 2, bank stays 0;
   - at JSB decode bank=3, rom_en=8'h08, pend_valid=0;
   - immediate select issued after a delayed select clears pend_valid.
4. Sync held high 9 cycles, and separately 11 cycles → instr_err one-cycle pulse each, bank/pend unchanged even when the word encodes a select.
5. NBANK=6, immediate select to 7 → instr_err pulse, bank unchanged; delayed select to 6 → instr_err pulse, pend_valid stays 0.
6. Sync stopped for 64 cycles → sync_lost=1 at cycle WD_LIMIT after the last rising edge; next valid word clears it. Then pon pulsed mid-SHIFT → immediate return to bank=RESET_BANK, no decode of the partial word.
